fetch_npc: RTL and testbench

Fetch-stage program counter and IF/ID pipeline register for the five-stage MIPS core. Selects the next PC from sequential, branch, jump and register-jump sources, using the decode-stage branch decision and forwarded register value. Registers the fetched instruction and its PC into the decode stage. Branches resolve in D with one architectural delay slot, so there is never a flush.

---
 rtl/fetch_npc.sv | 75 +++++++
 tb/tb_fetch_npc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_npc.sv
// Fetch-stage PC, next-PC selection and IF/ID pipeline register for the
// five-stage MIPS core. Branches and jumps resolve in D with one delay slot.
module fetch_npc #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] instr_f,
   input  logic [2:0]  npc_op,
   input  logic        is_branch,
   input  logic [15:0] imm16_d,
   input  logic [25:0] index_d,
   input  logic [31:0] rs_d,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        misalign_f
);

   localparam int unsigned XLEN    = 32;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned INDEX_W = 26;

   localparam logic [2:0] OP_BRANCH = 3'd1;
   localparam logic [2:0] OP_JUMP   = 3'd2;
   localparam logic [2:0] OP_JREG   = 3'd3;

   logic [XLEN-1:0] npc;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] br_off;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;

   // Candidate targets; all arithmetic wraps modulo 2^32
   always_comb begin
      seq_pc    = pc_f + XLEN'(4);
      br_off    = {{(XLEN-IMM_W-2){imm16_d[IMM_W-1]}}, imm16_d, 2'b00};
      br_target = pc_d + XLEN'(4) + br_off;
      j_target  = {pc_d[XLEN-1:INDEX_W+2], index_d, 2'b00};
   end

   // Next-PC select from the decode-stage control; undefined ops fall through
   always_comb begin
      npc = seq_pc;
      case (npc_op)
         OP_BRANCH: if (is_branch) npc = br_target;
         OP_JUMP:   npc = j_target;
         OP_JREG:   npc = rs_d;
         default:   npc = seq_pc;
      endcase
   end

   // PC and IF/ID register; a stall holds everything so the D instruction
   // re-presents its redirect and it is applied exactly once on release
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f    <= PC_RESET;
         instr_d <= '0;
         pc_d    <= '0;
      end else if (!stall) begin
         pc_f    <= npc;
         instr_d <= instr_f;
         pc_d    <= pc_f;
      end
   end

   // Link address and fetch alignment flag, no register stage
   always_comb begin
      pc8_d      = pc_d + XLEN'(8);
      misalign_f = |pc_f[1:0];
   end

endmodule

// File: tb/tb_fetch_npc.sv
// Self-checking bench for fetch_npc: directed vector table followed by
// randomized traffic checked against a behavioural model of the PC rules.
module tb_fetch_npc;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [31:0] instr_f;
   logic [2:0]  npc_op;
   logic        is_branch;
   logic [15:0] imm16_d;
   logic [25:0] index_d;
   logic [31:0] rs_d;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        misalign_f;

   int checks = 0;
   int errors = 0;

   fetch_npc #(.PC_RESET(PC_RESET)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .instr_f    (instr_f),
      .npc_op     (npc_op),
      .is_branch  (is_branch),
      .imm16_d    (imm16_d),
      .index_d    (index_d),
      .rs_d       (rs_d),
      .pc_f       (pc_f),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pc8_d      (pc8_d),
      .misalign_f (misalign_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory stand-in: distinct, nonzero word for every address
   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   always_comb instr_f = imem(pc_f);

   typedef struct {
      logic        rst;
      logic        stl;
      logic [2:0]  op;
      logic        br;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] rs;
      logic [31:0] e_pcf;
      logic [31:0] e_pcd;
      logic [31:0] e_ins;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stl, input logic [2:0] op,
                      input logic br, input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] rs, input logic [31:0] e_pcf,
                      input logic [31:0] e_pcd);
      vec_t v;
      v.rst = rst; v.stl = stl; v.op = op; v.br = br;
      v.imm = imm; v.idx = idx; v.rs = rs;
      v.e_pcf = e_pcf; v.e_pcd = e_pcd;
      v.e_ins = rst ? 32'h0 : imem(e_pcd);
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input logic [2:0] op,
                        input logic br, input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] rs);
      reset = rst; stall = stl; npc_op = op; is_branch = br;
      imm16_d = imm; index_d = idx; rs_d = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pcf,
                            input logic [31:0] e_pcd, input logic [31:0] e_ins);
      chk({tag, " pc_f"}, pc_f, e_pcf);
      chk({tag, " pc_d"}, pc_d, e_pcd);
      chk({tag, " instr_d"}, instr_d, e_ins);
      chk({tag, " pc8_d"}, pc8_d, e_pcd + 32'd8);
      chk({tag, " misalign_f"}, 32'(misalign_f), 32'(e_pcf[1:0] != 2'b00));
   endtask

   // Reference model state: fetch PC, decode PC, decode instruction
   logic [31:0] m_pcf, m_pcd, m_ins;

   task automatic model_step(input logic rst, input logic stl, input logic [2:0] op,
                             input logic br, input logic [15:0] imm, input logic [25:0] idx,
                             input logic [31:0] rs);
      logic [31:0] nxt;
      int          off;
      if (rst) begin
         m_pcf = PC_RESET; m_pcd = 32'h0; m_ins = 32'h0;
      end else if (!stl) begin
         off = int'($signed(imm)) * 4;
         if (op == 3'd1 && br)  nxt = m_pcd + 32'd4 + 32'(off);
         else if (op == 3'd2)   nxt = (m_pcd & 32'hF000_0000) | (32'(idx) * 32'd4);
         else if (op == 3'd3)   nxt = rs;
         else                   nxt = m_pcf + 32'd4;
         m_ins = imem(m_pcf);
         m_pcd = m_pcf;
         m_pcf = nxt;
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; npc_op = 3'd0; is_branch = 1'b0;
      imm16_d = '0; index_d = '0; rs_d = '0;

      // rst stl op br imm idx rs -> pc_f pc_d
      add(1, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3000, 32'h0);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3004, 32'h0000_3000);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3008, 32'h0000_3004);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_300C, 32'h0000_3008);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3010, 32'h0000_300C);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3014, 32'h0000_3010);
      // taken branch at 0x3010, offset -4 words
      add(0, 0, 1, 1, 16'hFFFC, 26'h0,       32'h0,         32'h0000_3004, 32'h0000_3014);
      add(0, 0, 3, 0, 16'h0,    26'h0,       32'h0000_3010, 32'h0000_3010, 32'h0000_3004);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3014, 32'h0000_3010);
      // not-taken branch at 0x3010
      add(0, 0, 1, 0, 16'hFFFC, 26'h0,       32'h0,         32'h0000_3018, 32'h0000_3014);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_301C, 32'h0000_3018);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3020, 32'h0000_301C);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3024, 32'h0000_3020);
      // j at 0x3020
      add(0, 0, 2, 0, 16'h0,    26'h000_0C10, 32'h0,        32'h0000_3040, 32'h0000_3024);
      // jr to a misaligned target
      add(0, 0, 3, 0, 16'h0,    26'h0,       32'h0000_3102, 32'h0000_3102, 32'h0000_3040);
      add(0, 0, 3, 0, 16'h0,    26'h0,       32'h0000_3200, 32'h0000_3200, 32'h0000_3102);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3204, 32'h0000_3200);
      // taken branch at 0x3200 held by a 3-cycle stall
      add(0, 1, 1, 1, 16'h0010, 26'h0,       32'h0,         32'h0000_3204, 32'h0000_3200);
      add(0, 1, 1, 1, 16'h0010, 26'h0,       32'h0,         32'h0000_3204, 32'h0000_3200);
      add(0, 1, 1, 1, 16'h0010, 26'h0,       32'h0,         32'h0000_3204, 32'h0000_3200);
      add(0, 0, 1, 1, 16'h0010, 26'h0,       32'h0,         32'h0000_3244, 32'h0000_3204);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3248, 32'h0000_3244);
      // wrap-around through the top of the address space
      add(0, 0, 3, 0, 16'h0,    26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3248);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_0000, 32'hFFFF_FFFC);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_0004, 32'h0000_0000);
      add(0, 0, 1, 1, 16'h8000, 26'h0,       32'h0,         32'hFFFE_0004, 32'h0000_0004);
      // reset together with stall and a pending jump, then held
      add(1, 1, 2, 0, 16'h0,    26'h3FF_FFFF, 32'h0,        32'h0000_3000, 32'h0);
      add(1, 1, 2, 0, 16'h0,    26'h3FF_FFFF, 32'h0,        32'h0000_3000, 32'h0);
      add(0, 0, 0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3004, 32'h0000_3000);
      // undefined ops behave as sequential
      add(0, 0, 5, 1, 16'h0004, 26'h0,       32'h0,         32'h0000_3008, 32'h0000_3004);
      add(0, 0, 7, 1, 16'h0004, 26'h1,       32'h0000_0040, 32'h0000_300C, 32'h0000_3008);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stl, vecs[i].op, vecs[i].br,
               vecs[i].imm, vecs[i].idx, vecs[i].rs);
         check_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_pcd, vecs[i].e_ins);
      end

      // Randomized traffic against the behavioural model
      drive(1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
      model_step(1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
      check_all("rnd_reset", m_pcf, m_pcd, m_ins);
      for (int n = 0; n < 2000; n++) begin
         logic        r, s, b;
         logic [2:0]  op;
         logic [15:0] imm;
         logic [25:0] idx;
         logic [31:0] rs;
         r   = ($urandom_range(0, 63) == 0);
         s   = ($urandom_range(0, 3) == 0);
         b   = 1'($urandom_range(0, 1));
         op  = 3'($urandom_range(0, 7));
         imm = 16'($urandom);
         idx = 26'($urandom);
         rs  = $urandom;
         if ($urandom_range(0, 1) == 1) rs = {rs[31:2], 2'b00};
         drive(r, s, op, b, imm, idx, rs);
         model_step(r, s, op, b, imm, idx, rs);
         check_all($sformatf("rnd%0d", n), m_pcf, m_pcd, m_ins);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
